trigger_ctrl: RTL and testbench

//  Acquisition sequencer for the scope's double-buffered capture path. Watches the ADC

---
 rtl/trigger_ctrl.sv | 171 +++++++++++++++++
 tb/tb_trigger_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_ctrl.sv
// Acquisition sequencer: level/edge trigger with hysteresis, holdoff and
// AUTO timeout, driving a double-buffered capture path and MCU handshake.
module trigger_ctrl #(
    parameter int DW   = 8,
    parameter int HYST = 2,
    parameter int TO_W = 20,
    parameter int HO_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sample_en,
    input  logic [DW-1:0]   sample,
    input  logic [DW-1:0]   cfg_level,
    input  logic            cfg_edge,
    input  logic [1:0]      cfg_mode,
    input  logic [HO_W-1:0] cfg_holdoff,
    input  logic [TO_W-1:0] cfg_timeout,
    input  logic            arm,
    input  logic            cap_done,
    input  logic            mcu_ack,
    output logic            cap_start,
    output logic            data_ready,
    output logic            trig_forced,
    output logic            busy,
    output logic [2:0]      state_o,
    output logic [15:0]     trig_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HOLDOFF = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_READY   = 3'd4
    } state_t;

    localparam logic [1:0]    M_AUTO   = 2'd0;
    localparam logic [1:0]    M_NORMAL = 2'd1;
    localparam logic [1:0]    M_SINGLE = 2'd2;
    localparam logic [1:0]    M_STOP   = 2'd3;
    localparam logic [DW-1:0] HYST_V   = DW'(HYST);
    localparam logic [DW-1:0] MAX_V    = '1;

    state_t          state_q;
    logic            busy_q;
    logic            cap_start_q;
    logic            data_ready_q;
    logic            trig_forced_q;
    logic            armed_q;
    logic [15:0]     trig_cnt_q;
    logic [15:0]     trig_cnt_d;
    logic [HO_W-1:0] ho_cnt_q;
    logic [TO_W-1:0] to_cnt_q;

    logic [DW-1:0]   lvl_lo;
    logic [DW-1:0]   lvl_hi;
    logic            arm_cond;
    logic            edge_hit;
    logic            to_hit;
    logic            fire;
    logic [TO_W:0]   to_nxt;
    logic [TO_W:0]   to_lim;

    // Saturated hysteresis thresholds, edge detection and forced-trigger timeout
    always_comb begin
        lvl_lo   = (cfg_level > HYST_V) ? cfg_level - HYST_V : '0;
        lvl_hi   = (cfg_level < MAX_V - HYST_V) ? cfg_level + HYST_V : MAX_V;
        arm_cond = 1'b0;
        edge_hit = 1'b0;
        if (cfg_edge) begin
            arm_cond = sample > lvl_hi;
            edge_hit = armed_q && (sample <= cfg_level);
        end else begin
            arm_cond = sample < lvl_lo;
            edge_hit = armed_q && (sample >= cfg_level);
        end
        to_nxt = {1'b0, to_cnt_q} + (TO_W+1)'(1);
        to_lim = (cfg_timeout == '0) ? (TO_W+1)'(1) : {1'b0, cfg_timeout};
        to_hit = (cfg_mode == M_AUTO) && (to_nxt >= to_lim);
        fire   = (state_q == S_WAIT) && (cfg_mode != M_STOP) &&
                 sample_en && (edge_hit || to_hit);
        trig_cnt_d = trig_cnt_q + {15'd0, fire};
    end

    // Sequencer state, counters and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            busy_q        <= 1'b0;
            cap_start_q   <= 1'b0;
            data_ready_q  <= 1'b0;
            trig_forced_q <= 1'b0;
            armed_q       <= 1'b0;
            trig_cnt_q    <= '0;
            ho_cnt_q      <= '0;
            to_cnt_q      <= '0;
        end else begin
            cap_start_q <= fire;
            trig_cnt_q  <= trig_cnt_d;
            case (state_q)
                S_IDLE: begin
                    if (cfg_mode == M_AUTO || cfg_mode == M_NORMAL ||
                        (cfg_mode == M_SINGLE && arm)) begin
                        state_q  <= S_HOLDOFF;
                        busy_q   <= 1'b1;
                        ho_cnt_q <= '0;
                    end
                end
                S_HOLDOFF: begin
                    if (cfg_mode == M_STOP) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (ho_cnt_q >= cfg_holdoff) begin
                        state_q  <= S_WAIT;
                        armed_q  <= 1'b0;
                        to_cnt_q <= '0;
                    end else if (sample_en) begin
                        ho_cnt_q <= ho_cnt_q + HO_W'(1);
                    end
                end
                S_WAIT: begin
                    if (cfg_mode == M_STOP) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (fire) begin
                        state_q       <= S_CAPTURE;
                        trig_forced_q <= !edge_hit;
                    end else begin
                        if (sample_en)
                            armed_q <= armed_q | arm_cond;
                        if (cfg_mode != M_AUTO)
                            to_cnt_q <= '0;
                        else if (sample_en)
                            to_cnt_q <= to_nxt[TO_W-1:0];
                    end
                end
                S_CAPTURE: begin
                    if (cap_done) begin
                        state_q      <= S_READY;
                        data_ready_q <= 1'b1;
                    end
                end
                S_READY: begin
                    if (mcu_ack) begin
                        data_ready_q  <= 1'b0;
                        trig_forced_q <= 1'b0;
                        ho_cnt_q      <= '0;
                        if (cfg_mode == M_SINGLE || cfg_mode == M_STOP) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_HOLDOFF;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cap_start   = cap_start_q;
    assign data_ready  = data_ready_q;
    assign trig_forced = trig_forced_q;
    assign busy        = busy_q;
    assign state_o     = state_q;
    assign trig_cnt    = trig_cnt_q;

endmodule

// File: tb/tb_trigger_ctrl.sv
// Bench for trigger_ctrl: directed scenarios plus randomized traffic
// checked cycle by cycle against a behavioural model.
module tb_trigger_ctrl;

    localparam int DW   = 8;
    localparam int HYST = 2;
    localparam int TO_W = 20;
    localparam int HO_W = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            sample_en;
    logic [DW-1:0]   sample;
    logic [DW-1:0]   cfg_level;
    logic            cfg_edge;
    logic [1:0]      cfg_mode;
    logic [HO_W-1:0] cfg_holdoff;
    logic [TO_W-1:0] cfg_timeout;
    logic            arm;
    logic            cap_done;
    logic            mcu_ack;
    logic            cap_start;
    logic            data_ready;
    logic            trig_forced;
    logic            busy;
    logic [2:0]      state_o;
    logic [15:0]     trig_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // model state: phase uses the readback numbering 0..4
    int m_state, m_ho, m_to, m_cnt;
    bit m_armed, m_dr, m_tf, m_cs;

    always #5 clk = ~clk;

    trigger_ctrl #(.DW(DW), .HYST(HYST), .TO_W(TO_W), .HO_W(HO_W)) dut (
        .clk(clk), .rst(rst), .sample_en(sample_en), .sample(sample),
        .cfg_level(cfg_level), .cfg_edge(cfg_edge), .cfg_mode(cfg_mode),
        .cfg_holdoff(cfg_holdoff), .cfg_timeout(cfg_timeout), .arm(arm),
        .cap_done(cap_done), .mcu_ack(mcu_ack), .cap_start(cap_start),
        .data_ready(data_ready), .trig_forced(trig_forced), .busy(busy),
        .state_o(state_o), .trig_cnt(trig_cnt)
    );

    function automatic logic [22:0] obs();
        return {state_o, busy, data_ready, trig_forced, cap_start, trig_cnt};
    endfunction

    function automatic logic [22:0] expv();
        return {3'(m_state), m_state != 0, m_dr, m_tf, m_cs, 16'(m_cnt)};
    endfunction

    task automatic model_step();
        int lvl, s, tmo;
        bit hit, forced, arming;
        if (rst) begin
            m_state = 0; m_ho = 0; m_to = 0; m_cnt = 0;
            m_armed = 0; m_dr = 0; m_tf = 0; m_cs = 0;
            return;
        end
        m_cs = 0;
        lvl  = int'(cfg_level);
        s    = int'(sample);
        case (m_state)
            0: if (cfg_mode < 2 || (cfg_mode == 2 && arm)) begin
                m_state = 1; m_ho = 0;
            end
            1: if (cfg_mode == 3) m_state = 0;
               else if (m_ho >= int'(cfg_holdoff)) begin
                   m_state = 2; m_armed = 0; m_to = 0;
               end else if (sample_en) m_ho++;
            2: if (cfg_mode == 3) m_state = 0;
               else begin
                   if (sample_en) begin
                       hit    = m_armed && (cfg_edge ? s <= lvl : s >= lvl);
                       arming = cfg_edge ? (s > lvl + HYST) : (s < lvl - HYST);
                       tmo    = (cfg_timeout == 0) ? 1 : int'(cfg_timeout);
                       forced = (cfg_mode == 0) && (m_to + 1 >= tmo);
                       if (hit || forced) begin
                           m_cs = 1; m_cnt = (m_cnt + 1) % 65536;
                           m_tf = !hit; m_state = 3;
                       end else begin
                           m_armed = m_armed | arming;
                           if (cfg_mode == 0) m_to++;
                       end
                   end
                   if (cfg_mode != 0) m_to = 0;
               end
            3: if (cap_done) begin m_state = 4; m_dr = 1; end
            4: if (mcu_ack) begin
                m_dr = 0; m_tf = 0; m_ho = 0;
                m_state = (cfg_mode >= 2) ? 0 : 1;
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        sample_en = 0; arm = 0; cap_done = 0; mcu_ack = 0;
    endtask

    task automatic do_reset();
        rst = 1; tick(); rst = 0;
    endtask

    task automatic set_cfg(input int mode, input int lvl, input int edg,
                           input int ho, input int to);
        cfg_mode = 2'(mode); cfg_level = 8'(lvl); cfg_edge = 1'(edg);
        cfg_holdoff = 16'(ho); cfg_timeout = 20'(to);
    endtask

    // drive samples until the DUT reaches WAIT_TRIG (bounded)
    task automatic reach_wait(input string tag, input int val);
        int k = 0;
        while (state_o !== 3'd2 && k < 40) begin
            sample = 8'(val); sample_en = 1; tick(); k++;
        end
        n_cmp++;
        if (state_o !== 3'd2) begin
            n_fail++;
            $display("FAIL %s reach_wait: state %0d want 2", tag, state_o);
        end
    endtask

    task automatic test_reset();
        rst = 1; tick(); tick();
        n_cmp++;
        if (obs() !== 23'd0) begin
            n_fail++; $display("FAIL reset: got %h want 0", obs());
        end
        n_cmp++;
        if (obs() !== expv()) begin
            n_fail++; $display("FAIL reset_model: dut %h model %h", obs(), expv());
        end
        rst = 0;
    endtask

    task automatic test_normal_ramp();
        int pulses = 0, trig_val = -1;
        do_reset();
        set_cfg(1, 128, 0, 0, 10);
        for (int v = 100; v <= 160; v++) begin
            sample = 8'(v); sample_en = 1; tick();
            if (cap_start) begin pulses++; trig_val = v; end
            n_cmp++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL ramp v=%0d: dut %h model %h", v, obs(), expv());
            end
        end
        n_cmp++;
        if (pulses !== 1 || trig_val !== 128) begin
            n_fail++;
            $display("FAIL ramp_trig: pulses %0d at %0d want 1 at 128", pulses, trig_val);
        end
        n_cmp++;
        if (trig_cnt !== 16'd1) begin
            n_fail++; $display("FAIL ramp_cnt: got %0d want 1", trig_cnt);
        end
    endtask

    task automatic test_hysteresis();
        int seq[6] = '{127, 128, 127, 128, 125, 128};
        int early = 0, late = 0;
        do_reset();
        set_cfg(1, 128, 0, 0, 10);
        tick(); tick();
        for (int i = 0; i < 6; i++) begin
            sample = 8'(seq[i]); sample_en = 1; tick();
            if (cap_start) begin
                if (i < 5) early++; else late++;
            end
            n_cmp++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL hyst i=%0d: dut %h model %h", i, obs(), expv());
            end
        end
        n_cmp++;
        if (early !== 0 || late !== 1) begin
            n_fail++;
            $display("FAIL hyst_trig: early %0d late %0d want 0 1", early, late);
        end
    endtask

    task automatic test_auto_timeout();
        int n = 0;
        do_reset();
        set_cfg(0, 128, 0, 0, 10);
        reach_wait("auto", 50);
        while (n < 20 && !cap_start) begin
            sample = 8'd50; sample_en = 1; tick(); n++;
        end
        n_cmp++;
        if (n !== 10 || trig_forced !== 1'b1) begin
            n_fail++;
            $display("FAIL auto_to: fired after %0d forced %b want 10 1", n, trig_forced);
        end
        cap_done = 1; tick();
        n_cmp++;
        if (data_ready !== 1'b1 || trig_forced !== 1'b1 || state_o !== 3'd4) begin
            n_fail++;
            $display("FAIL auto_ready: dr %b tf %b st %0d want 1 1 4",
                     data_ready, trig_forced, state_o);
        end
        mcu_ack = 1; tick();
        n_cmp++;
        if (data_ready !== 1'b0 || trig_forced !== 1'b0 || state_o !== 3'd1) begin
            n_fail++;
            $display("FAIL auto_ack: dr %b tf %b st %0d want 0 0 1",
                     data_ready, trig_forced, state_o);
        end
    endtask

    task automatic test_single();
        int extra = 0;
        do_reset();
        set_cfg(2, 128, 0, 0, 10);
        for (int i = 0; i < 5; i++) begin
            sample = (i % 2) ? 8'd200 : 8'd100; sample_en = 1; tick();
        end
        n_cmp++;
        if (state_o !== 3'd0 || trig_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL single_idle: st %0d cnt %0d want 0 0", state_o, trig_cnt);
        end
        arm = 1; tick(); tick();
        sample = 8'd100; sample_en = 1; tick();
        sample = 8'd200; sample_en = 1; tick();
        n_cmp++;
        if (cap_start !== 1'b1 || obs() !== expv()) begin
            n_fail++;
            $display("FAIL single_trig: dut %h model %h", obs(), expv());
        end
        cap_done = 1; tick();
        n_cmp++;
        if (data_ready !== 1'b1) begin
            n_fail++; $display("FAIL single_dr: got %b want 1", data_ready);
        end
        mcu_ack = 1; tick();
        for (int i = 0; i < 10; i++) begin
            sample = (i % 2) ? 8'd200 : 8'd100; sample_en = 1; tick();
            if (cap_start || state_o !== 3'd0) extra++;
        end
        n_cmp++;
        if (extra !== 0 || trig_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL single_once: extra %0d cnt %0d want 0 1", extra, trig_cnt);
        end
    endtask

    task automatic test_holdoff();
        int seq[8] = '{120, 120, 130, 120, 120, 120, 120, 130};
        int pos = -1, cnt = 0;
        do_reset();
        set_cfg(1, 128, 0, 5, 10);
        reach_wait("holdoff", 100);
        sample = 8'd100; sample_en = 1; tick();
        sample = 8'd130; sample_en = 1; tick();
        cap_done = 1; tick();
        mcu_ack = 1; tick();
        for (int i = 0; i < 8; i++) begin
            sample = 8'(seq[i]); sample_en = 1; tick();
            if (cap_start) begin cnt++; pos = i; end
            n_cmp++;
            if (obs() !== expv()) begin
                n_fail++;
                $display("FAIL holdoff i=%0d: dut %h model %h", i, obs(), expv());
            end
        end
        n_cmp++;
        if (cnt !== 1 || pos !== 7 || trig_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL holdoff_trig: cnt %0d pos %0d tc %0d want 1 7 2",
                     cnt, pos, trig_cnt);
        end
    endtask

    task automatic test_stop_and_reset();
        do_reset();
        set_cfg(1, 128, 0, 0, 10);
        tick(); tick();
        sample = 8'd100; sample_en = 1; tick();
        cfg_mode = 2'd3;
        sample = 8'd130; sample_en = 1; tick();
        n_cmp++;
        if (state_o !== 3'd0 || cap_start !== 1'b0 || trig_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL stop: st %0d cs %b cnt %0d want 0 0 0",
                     state_o, cap_start, trig_cnt);
        end
        cfg_mode = 2'd1;
        tick(); tick();
        sample = 8'd100; sample_en = 1; tick();
        sample = 8'd130; sample_en = 1; tick();
        n_cmp++;
        if (state_o !== 3'd3 || cap_start !== 1'b1) begin
            n_fail++;
            $display("FAIL stop_rearm: st %0d cs %b want 3 1", state_o, cap_start);
        end
        rst = 1; tick(); rst = 0;
        n_cmp++;
        if (obs() !== 23'd0) begin
            n_fail++; $display("FAIL rst_capture: got %h want 0", obs());
        end
    endtask

    task automatic test_wrap();
        logic [15:0] want[3] = '{16'hFFFF, 16'h0000, 16'h0001};
        do_reset();
        set_cfg(1, 128, 0, 0, 10);
        force dut.trig_cnt_q = 16'hFFFE;
        tick();
        release dut.trig_cnt_q;
        m_cnt = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            reach_wait("wrap", 100);
            sample = 8'd100; sample_en = 1; tick();
            sample = 8'd130; sample_en = 1; tick();
            n_cmp++;
            if (trig_cnt !== want[i] || obs() !== expv()) begin
                n_fail++;
                $display("FAIL wrap%0d: cnt %h want %h", i, trig_cnt, want[i]);
            end
            cap_done = 1; tick();
            mcu_ack = 1; tick();
        end
    endtask

    task automatic test_random();
        int s, lvl;
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            lvl = (seg == 1) ? $urandom_range(0, 3) :
                  (seg == 2) ? $urandom_range(252, 255) : $urandom_range(0, 255);
            set_cfg($urandom_range(0, 2), lvl, $urandom_range(0, 1),
                    $urandom_range(0, 4), $urandom_range(0, 12));
            for (int c = 0; c < 500; c++) begin
                if ($urandom_range(0, 63) == 0) cfg_mode = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) s = $urandom_range(0, 255);
                else s = int'(cfg_level) + $urandom_range(0, 16) - 8;
                if (s < 0) s = 0;
                if (s > 255) s = 255;
                sample    = 8'(s);
                sample_en = ($urandom_range(0, 1) == 1);
                arm       = ($urandom_range(0, 7) == 0);
                cap_done  = ($urandom_range(0, 5) == 0);
                mcu_ack   = ($urandom_range(0, 5) == 0);
                rst       = ($urandom_range(0, 299) == 0);
                tick();
                rst = 0;
                n_cmp++;
                if (obs() !== expv()) begin
                    n_fail++;
                    $display("FAIL random seg%0d c%0d: dut %h model %h",
                             seg, c, obs(), expv());
                end
            end
        end
    endtask

    initial begin
        rst = 1; sample_en = 0; sample = '0; arm = 0; cap_done = 0; mcu_ack = 0;
        set_cfg(3, 128, 0, 0, 10);
        @(negedge clk);
        test_reset();
        test_normal_ramp();
        test_hysteresis();
        test_auto_timeout();
        test_single();
        test_holdoff();
        test_stop_and_reset();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
